game_round_ctrl: RTL and testbench



---
 rtl/game_round_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_game_round_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer for the multimode counter game.
// Steps the game counter by +1/+2/-1/-2 according to mode, scores a win on
// every landing at all-ones and a loss on every landing at zero, and holds a
// game-over result for HOLD_CYCLES cycles once either score saturates, then
// restarts the round on its own.
// Optional build macro GAME_PAUSE_EN adds a 'pause' input that freezes the
// round while running (ignored during the game-over hold).
// who encoding: 0 = none, 1 = loser side won, 2 = winner side won.
module game_round_ctrl #(
  parameter int WIDTH       = 4,
  parameter int SCORE_W     = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef GAME_PAUSE_EN
  input  logic               pause,
`endif
  input  logic [1:0]         mode,
  input  logic               init,
  input  logic [WIDTH-1:0]   init_value,
  output logic [WIDTH-1:0]   count,
  output logic [SCORE_W-1:0] winner_cnt,
  output logic [SCORE_W-1:0] loser_cnt,
  output logic               winner_pulse,
  output logic               loser_pulse,
  output logic               gameover,
  output logic [1:0]         who
);

  localparam logic STATE_RUN  = 1'b0;
  localparam logic STATE_OVER = 1'b1;

  localparam logic [WIDTH-1:0]   CNT_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   CNT_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   STEP_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   STEP_TWO  = {{(WIDTH-2){1'b0}}, 2'b10};
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};
  localparam logic [SCORE_W-1:0] SCORE_ZERO = {SCORE_W{1'b0}};
  // Hold timer is 8 bits wide because HOLD_CYCLES is limited to 1..255.
  localparam logic [7:0]         HOLD_LAST = 8'(HOLD_CYCLES - 32'sd1);

  localparam logic [1:0] WHO_NONE   = 2'd0;
  localparam logic [1:0] WHO_LOSER  = 2'd1;
  localparam logic [1:0] WHO_WINNER = 2'd2;

  // Modular step of the game counter; wrap-around is intentional and silent.
  function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] cur,
                                                  input logic [1:0]       sel);
    logic [WIDTH-1:0] nxt;
    case (sel)
      2'b00:   nxt = cur + STEP_ONE;
      2'b01:   nxt = cur + STEP_TWO;
      2'b10:   nxt = cur - STEP_ONE;
      2'b11:   nxt = cur - STEP_TWO;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  logic                 state_q, state_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [SCORE_W-1:0]   win_q, win_d;
  logic [SCORE_W-1:0]   lose_q, lose_d;
  logic                 wp_q, wp_d;
  logic                 lp_q, lp_d;
  logic                 go_q, go_d;
  logic [1:0]           who_q, who_d;
  logic [7:0]           hold_q, hold_d;
  logic [WIDTH-1:0]     next_s;
  logic                 pause_s;

`ifdef GAME_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  assign next_s = step_count(count_q, mode);

  // Next-state logic: run/score while in RUN, count out the hold in OVER.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    win_d   = win_q;
    lose_d  = lose_q;
    wp_d    = 1'b0;
    lp_d    = 1'b0;
    go_d    = go_q;
    who_d   = who_q;
    hold_d  = hold_q;
    case (state_q)
      STATE_RUN: begin
        if (pause_s) begin
          // Frozen round: everything holds, pulses stay low.
          count_d = count_q;
        end else if (init) begin
          // A load never scores, even when it lands on all-ones or zero.
          count_d = init_value;
        end else begin
          count_d = next_s;
          if (next_s == CNT_ONES) begin
            wp_d  = 1'b1;
            win_d = win_q + SCORE_ONE;
            if (win_d == SCORE_MAX) begin
              go_d    = 1'b1;
              who_d   = WHO_WINNER;
              hold_d  = 8'd0;
              state_d = STATE_OVER;
            end else begin
              state_d = STATE_RUN;
            end
          end else if (next_s == CNT_ZERO) begin
            lp_d   = 1'b1;
            lose_d = lose_q + SCORE_ONE;
            if (lose_d == SCORE_MAX) begin
              go_d    = 1'b1;
              who_d   = WHO_LOSER;
              hold_d  = 8'd0;
              state_d = STATE_OVER;
            end else begin
              state_d = STATE_RUN;
            end
          end else begin
            wp_d = 1'b0;
            lp_d = 1'b0;
          end
        end
      end
      STATE_OVER: begin
        // Inputs are ignored here; only the hold timer advances.
        if (hold_q == HOLD_LAST) begin
          count_d = CNT_ZERO;
          win_d   = SCORE_ZERO;
          lose_d  = SCORE_ZERO;
          go_d    = 1'b0;
          who_d   = WHO_NONE;
          hold_d  = 8'd0;
          state_d = STATE_RUN;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a clean, idle round.
        count_d = CNT_ZERO;
        win_d   = SCORE_ZERO;
        lose_d  = SCORE_ZERO;
        go_d    = 1'b0;
        who_d   = WHO_NONE;
        hold_d  = 8'd0;
        state_d = STATE_RUN;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STATE_RUN;
      count_q <= CNT_ZERO;
      win_q   <= SCORE_ZERO;
      lose_q  <= SCORE_ZERO;
      wp_q    <= 1'b0;
      lp_q    <= 1'b0;
      go_q    <= 1'b0;
      who_q   <= WHO_NONE;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      wp_q    <= wp_d;
      lp_q    <= lp_d;
      go_q    <= go_d;
      who_q   <= who_d;
      hold_q  <= hold_d;
    end
  end

  assign count        = count_q;
  assign winner_cnt   = win_q;
  assign loser_cnt    = lose_q;
  assign winner_pulse = wp_q;
  assign loser_pulse  = lp_q;
  assign gameover     = go_q;
  assign who          = who_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: directed scenarios plus a random
// run, all compared against an integer-arithmetic model of the game rules.
module tb_game_round_ctrl;

  localparam int W    = 4;
  localparam int SW   = 4;
  localparam int HOLD = 4;
  localparam int SMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pause = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          init = 1'b0;
  logic [W-1:0]  init_value = 4'd0;
  logic [W-1:0]  count;
  logic [SW-1:0] winner_cnt;
  logic [SW-1:0] loser_cnt;
  logic          winner_pulse;
  logic          loser_pulse;
  logic          gameover;
  logic [1:0]    who;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state (plain integers).
  int m_cnt, m_win, m_lose, m_who, m_hold_left;
  bit m_wp, m_lp, m_go;

  game_round_ctrl #(.WIDTH(W), .SCORE_W(SW), .HOLD_CYCLES(HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef GAME_PAUSE_EN
    .pause        (pause),
`endif
    .mode         (mode),
    .init         (init),
    .init_value   (init_value),
    .count        (count),
    .winner_cnt   (winner_cnt),
    .loser_cnt    (loser_cnt),
    .winner_pulse (winner_pulse),
    .loser_pulse  (loser_pulse),
    .gameover     (gameover),
    .who          (who)
  );

  always #5 clk = ~clk;

  wire [16:0] dut_vec = {count, winner_cnt, loser_cnt, winner_pulse,
                         loser_pulse, gameover, who};

  function automatic logic [16:0] exp_vec();
    return {4'(m_cnt), 4'(m_win), 4'(m_lose), m_wp, m_lp, m_go, 2'(m_who)};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_win = 0; m_lose = 0; m_who = 0; m_hold_left = 0;
    m_wp = 1'b0; m_lp = 1'b0; m_go = 1'b0;
  endtask

  // One clock edge of the game rules, using the inputs present at the edge.
  task automatic model_step();
    int delta;
    bit eff_pause;
    eff_pause = 1'b0;
`ifdef GAME_PAUSE_EN
    eff_pause = pause;
`endif
    m_wp = 1'b0;
    m_lp = 1'b0;
    if (m_go) begin
      m_hold_left = m_hold_left - 1;
      if (m_hold_left == 0) begin
        m_cnt = 0; m_win = 0; m_lose = 0; m_go = 1'b0; m_who = 0;
      end
    end else if (!eff_pause) begin
      if (init) begin
        m_cnt = int'(init_value);
      end else begin
        case (mode)
          2'd0: delta = 1;
          2'd1: delta = 2;
          2'd2: delta = -1;
          default: delta = -2;
        endcase
        m_cnt = (((m_cnt + delta) % 16) + 16) % 16;
        if (m_cnt == 15) begin
          m_wp = 1'b1;
          m_win = m_win + 1;
          if (m_win == SMAX) begin m_go = 1'b1; m_who = 2; m_hold_left = HOLD; end
        end else if (m_cnt == 0) begin
          m_lp = 1'b1;
          m_lose = m_lose + 1;
          if (m_lose == SMAX) begin m_go = 1'b1; m_who = 1; m_hold_left = HOLD; end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    init = 1'b0; mode = 2'd0; init_value = 4'd0; pause = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    n_cmp++;
    if (dut_vec !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_state got %h want %h", dut_vec, 17'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    do_reset();
    mode = 2'd0; init = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL count_up step %0d got %h want %h", i, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if ({count, winner_pulse, winner_cnt, loser_cnt} !== {4'd15, 1'b1, 4'd1, 4'd0}) begin
      n_fail++;
      $display("FAIL count_up_end got %h want %h",
               {count, winner_pulse, winner_cnt, loser_cnt}, {4'd15, 1'b1, 4'd1, 4'd0});
    end
  endtask

  task automatic test_init_wrap();
    do_reset();
    mode = 2'd2; init = 1'b0;
    tick();
    n_cmp++;
    if ({count, winner_pulse} !== {4'd15, 1'b1}) begin
      n_fail++;
      $display("FAIL dec_from_zero got %h want %h", {count, winner_pulse}, {4'd15, 1'b1});
    end
    init = 1'b1; init_value = 4'd1;
    tick();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL load_one got %h want %h", dut_vec, exp_vec());
    end
    init = 1'b0; mode = 2'd2;
    tick();
    n_cmp++;
    if ({count, loser_pulse, loser_cnt} !== {4'd0, 1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL dec_to_zero got %h want %h", {count, loser_pulse, loser_cnt}, {4'd0, 1'b1, 4'd1});
    end
    init = 1'b1; init_value = 4'd14; mode = 2'd1;
    tick();
    n_cmp++;
    if ({count, winner_pulse, loser_pulse} !== {4'd14, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL load_priority got %h want %h", {count, winner_pulse, loser_pulse}, {4'd14, 2'b00});
    end
    init = 1'b0;
    tick();
    n_cmp++;
    if ({count, loser_pulse} !== {4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_plus2 got %h want %h", {count, loser_pulse}, {4'd0, 1'b1});
    end
    mode = 2'd0;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL climb step %0d got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_win_gameover();
    do_reset();
    for (int k = 0; k < 15; k++) begin
      init = 1'b1; init_value = 4'd14; mode = 2'($urandom_range(0, 3));
      tick();
      init = 1'b0; mode = 2'd0;
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL win_build %0d got %h want %h", k, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if ({gameover, who, winner_cnt} !== {1'b1, 2'd2, 4'd15}) begin
      n_fail++;
      $display("FAIL win_saturate got %h want %h", {gameover, who, winner_cnt}, {1'b1, 2'd2, 4'd15});
    end
    for (int j = 0; j < HOLD; j++) begin
      mode = 2'($urandom_range(0, 3));
      init = 1'($urandom_range(0, 1));
      init_value = 4'($urandom);
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL win_hold %0d got %h want %h", j, dut_vec, exp_vec());
      end
      if (j < HOLD - 1) begin
        n_cmp++;
        if ({gameover, count} !== {1'b1, 4'd15}) begin
          n_fail++;
          $display("FAIL hold_frozen %0d got %h want %h", j, {gameover, count}, {1'b1, 4'd15});
        end
      end else begin
        n_cmp++;
        if (dut_vec !== 17'h0) begin
          n_fail++;
          $display("FAIL auto_restart got %h want %h", dut_vec, 17'h0);
        end
      end
    end
    init = 1'b0; mode = 2'd2;
    tick();
    n_cmp++;
    if ({count, winner_pulse, winner_cnt} !== {4'd15, 1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL first_after_restart got %h want %h",
               {count, winner_pulse, winner_cnt}, {4'd15, 1'b1, 4'd1});
    end
  endtask

  task automatic test_loss_reset_midhold();
    do_reset();
    for (int k = 0; k < 15; k++) begin
      init = 1'b1; init_value = 4'd1;
      tick();
      init = 1'b0; mode = 2'd2;
      tick();
    end
    n_cmp++;
    if ({gameover, who, loser_cnt} !== {1'b1, 2'd1, 4'd15}) begin
      n_fail++;
      $display("FAIL loss_saturate got %h want %h", {gameover, who, loser_cnt}, {1'b1, 2'd1, 4'd15});
    end
    tick();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL loss_hold got %h want %h", dut_vec, exp_vec());
    end
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec !== 17'h0) begin
      n_fail++;
      $display("FAIL async_reset_midhold got %h want %h", dut_vec, 17'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      mode = 2'($urandom_range(0, 3));
      init = ($urandom_range(0, 7) == 0);
      init_value = 4'($urandom);
`ifdef GAME_PAUSE_EN
      pause = ($urandom_range(0, 5) == 0);
`endif
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d got %h want %h", i, dut_vec, exp_vec());
      end
    end
    pause = 1'b0; init = 1'b0;
  endtask

`ifdef GAME_PAUSE_EN
  task automatic test_pause();
    do_reset();
    init = 1'b1; init_value = 4'd7;
    tick();
    init = 1'b0; pause = 1'b1; mode = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({count, winner_pulse, loser_pulse} !== {4'd7, 2'b00}) begin
        n_fail++;
        $display("FAIL pause_hold %0d got %h want %h", i, {count, winner_pulse, loser_pulse}, {4'd7, 2'b00});
      end
    end
    init = 1'b1; init_value = 4'd3;
    tick();
    n_cmp++;
    if (count !== 4'd7) begin
      n_fail++;
      $display("FAIL pause_over_init got %h want %h", count, 4'd7);
    end
    pause = 1'b0; init = 1'b0;
    tick();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL pause_release got %h want %h", dut_vec, exp_vec());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_init_wrap();
    test_win_gameover();
    test_loss_reset_midhold();
`ifdef GAME_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
